// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the memory bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

   // Responder control states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACCESS  = 2'd2,
      RESPOND = 2'd3
   } state_e;

   // Wait-state counter width; covers 0..15 programmed wait states
   localparam int WAIT_CNT_W = 4;

   // Byte address of word 0 of the data segment
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_array
// Description : Word storage with synchronous write and registered read.
//               Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_array
   import mem_bus_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int MEMORY_DEPTH = 256,
   parameter int IDX_W        = 8
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [IDX_W-1:0]      idx_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   // Read register only updates on a read strobe so the value holds afterwards
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem_q[idx_i];
      end
   end

   // Storage write port and read data register
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule : mem_word_array
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_responder
// Description : Memory-side responder for the load/store port. Accepts one
//               word request at a time, inserts programmable wait states,
//               decodes the data segment and returns data or an error.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int          DATA_WIDTH   = 32,
   parameter int          MEMORY_DEPTH = 256,
   parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
   parameter int          WAIT_STATES  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [31:0]           req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_error_o,
   output logic                  busy_o
);

   localparam int          IDX_W      = $clog2(MEMORY_DEPTH);
   localparam logic [31:0] SPAN_BYTES = 32'(4 * MEMORY_DEPTH);

   state_e                  state_q,    state_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                    write_q,    write_d;
   logic [IDX_W-1:0]        idx_q,      idx_d;
   logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
   logic                    error_q,    error_d;

   logic [31:0]             offset;
   logic                    addr_ok;
   logic                    arr_we;
   logic                    arr_re;
   logic [DATA_WIDTH-1:0]   arr_rdata;

   // Address decode; the lower-bound compare guards against the subtraction
   // wrapping below the base into an apparently valid index
   always_comb begin
      offset  = req_addr_i - BASE_ADDR;
      addr_ok = (req_addr_i >= BASE_ADDR) && (offset < SPAN_BYTES) &&
                (req_addr_i[1:0] == 2'b00);
   end

   // Next-state logic and request capture
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      write_d    = write_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      error_d    = error_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               wdata_d = req_wdata_i;
               idx_d   = offset[IDX_W+1:2];
               if (!addr_ok) begin
                  error_d = 1'b1;
                  state_d = RESPOND;
               end else if (WAIT_STATES == 0) begin
                  state_d = ACCESS;
               end else begin
                  wait_cnt_d = WAIT_CNT_W'(WAIT_STATES - 1);
                  state_d    = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = ACCESS;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         ACCESS: begin
            state_d = RESPOND;
         end
         RESPOND: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
               error_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and captured-request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         write_q    <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         write_q    <= write_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         error_q    <= error_d;
      end
   end

   // The array has no reset, so the write strobe itself must yield to reset
   assign arr_we = (state_q == ACCESS) && write_q && !reset;
   assign arr_re = (state_q == ACCESS) && !write_q;

   mem_word_array #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MEMORY_DEPTH (MEMORY_DEPTH),
      .IDX_W        (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   // Load data is exposed only while responding to a good load; else zero
   assign rsp_rdata_o = (state_q == RESPOND && !error_q && !write_q) ? arr_rdata : '0;
   assign rsp_error_o = error_q;
   assign rsp_valid_o = (state_q == RESPOND);
   assign req_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);

endmodule : mem_bus_responder
`default_nettype wire

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the processor's load/store port.
- Accepts word read/write requests over a valid/ready request channel and inserts a programmable number of wait states.
- Decodes the data segment (base 0x10010000) and returns read data or an error over a valid/ready response channel.
- Replaces the zero-latency combinational data memory, so the core can later be stalled on real memory timing.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- MEMORY_DEPTH, 256, number of words stored.
- BASE_ADDR, 32'h10010000, byte address of word 0.
- WAIT_STATES, 2, idle cycles between request accept and array access (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears control state, not array contents.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_write_i  input  1  1 = store word, 0 = load word.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  DATA_WIDTH  store data.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  requester takes the response.
- rsp_rdata_o  output  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_error_o  output  1  request out of range or misaligned.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, busy_o=0, state=IDLE, wait counter=0.
- Reset has priority over every other event, including an ACCESS cycle. A store caught in WAIT or ACCESS when reset asserts is never committed.
- FSM states: IDLE, WAIT, ACCESS, RESPOND.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, capture write, addr and wdata into registers.
  - Address decode: offset = addr - BASE_ADDR. Valid iff addr >= BASE_ADDR, offset < 4*MEMORY_DEPTH and addr[1:0]==0.
  - Invalid address: go to RESPOND with error=1, rdata=0; the array is not touched.
  - Valid, WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
  - Valid, WAIT_STATES==0: go to ACCESS.
- WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle; at 0, go to ACCESS.
  - Changes on req_* inputs are ignored because the captured copy is used.
- ACCESS (exactly one cycle):
  - Word index = offset[log2(MEMORY_DEPTH)+1:2].
  - Store: write wdata at that index; rdata register = 0.
  - Load: registered read of that index into the rdata register.
  - Next state RESPOND.
- RESPOND:
  - rsp_valid_o=1; rsp_rdata_o and rsp_error_o held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE, drop rsp_valid_o and clear rdata/error to 0.
  - req_ready_o=0 throughout; a new request is accepted at the earliest in the cycle after the handshake (no overlap).
- Latency, measured from the accept edge:
  - rsp_valid_o rises WAIT_STATES+2 cycles later for a valid request.
  - rsp_valid_o rises 1 cycle later for an error.
  - Back-to-back throughput is one transaction per WAIT_STATES+3 cycles when rsp_ready_i is tied high.
- A load from a word stored in the previous transaction returns the new value.
- Boundary cases:
  - addr = BASE_ADDR+4*MEMORY_DEPTH-4 is valid (last word).
  - addr = BASE_ADDR+4*MEMORY_DEPTH is an error.
  - addr = BASE_ADDR-4 is an error; the subtraction must not wrap into a valid index, so compare before indexing.
- Holding rsp_ready_i low stalls indefinitely in RESPOND with no data change.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum {IDLE, WAIT, ACCESS, RESPOND};
  - WAIT_CNT_W = 4;
  - DEFAULT_BASE_ADDR = 32'h10010000.
- Sub-module mem_word_array: MEMORY_DEPTH x DATA_WIDTH storage with synchronous write enable and registered read. It has no reset and is driven only in ACCESS.

Test Plan:
- Store 0xDEADBEEF at 0x10010004, then load 0x10010004. Required: load returns rdata=0xDEADBEEF, error=0; rsp_valid_o rises 4 cycles after accept (WAIT_STATES=2).
- Load 0x10010002 (misaligned). Required: rsp_valid_o rises 1 cycle after accept with error=1, rdata=0; the array is unchanged.
- Load 0x100103FC, then load 0x10010400. Required: first returns stored data with error=0; second returns error=1.
- Load, holding rsp_ready_i=0 for 5 cycles. Required: rsp_valid_o, rsp_rdata_o and rsp_error_o stay stable; req_ready_o=0; IDLE is entered on the cycle after rsp_ready_i=1.
- Store 0x12345678 to 0x10010008 and assert reset in the WAIT cycle. Required: all outputs return to reset values next cycle; a later load of 0x10010008 returns the prior value (0x00000000 after preload).
- Instance with WAIT_STATES=0, back-to-back loads with rsp_ready_i tied high. Required: each rsp_valid_o arrives 2 cycles after accept, with one transaction every 3 cycles.
